alu_share_arbiter: RTL



---
 rtl/alu_share_arbiter_pkg.sv | 16 +
 rtl/alu_share_arbiter_alu8_core.sv | 29 ++
 rtl/alu_share_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU op-codes and the
// request/execute/respond FSM encoding.
package alu_share_arbiter_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_alu8_core.sv
// Purely combinational 8-bit ALU: add, sub (A + ~B + 1), xor, shift-left-by-1.
// carry is bit 8 of the 9-bit internal result (sub: 1 means no borrow).
module alu8_core
  import alu_share_arbiter_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] y,
  output logic       carry
);

  logic [8:0] sum_s;

  // Op decode into a 9-bit result so the carry falls out of bit 8 for every op
  always_comb begin
    sum_s = 9'd0;
    case (op)
      OP_ADD:  sum_s = {1'b0, a} + {1'b0, b};
      OP_SUB:  sum_s = {1'b0, a} + {1'b0, ~b} + 9'd1;
      OP_XOR:  sum_s = {1'b0, a ^ b};
      OP_SHL:  sum_s = {a, 1'b0};
      default: sum_s = 9'd0;
    endcase
    y     = sum_s[7:0];
    carry = sum_s[8];
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one alu8_core among NREQ requesters.
// Optional ALU_SHARE_FLAGS_EN adds registered rsp_carry/rsp_zero outputs.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic [IDW-1:0]       rsp_id,
`ifdef ALU_SHARE_FLAGS_EN
  output logic                 rsp_carry,
  output logic                 rsp_zero,
`endif
  output logic                 busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [1:0]       op_arr [NREQ];
  logic [7:0]       a_arr  [NREQ];
  logic [7:0]       b_arr  [NREQ];

  logic             grant_valid_s;
  logic [IDW-1:0]   grant_id_s;
  logic [NREQ-1:0]  req_ready_s;
  logic [7:0]       alu_y_s;

`ifdef ALU_SHARE_FLAGS_EN
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             alu_carry_s;
`else
  logic             unused_alu_carry_s;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[2*g +: 2];
    assign a_arr[g]  = req_a[8*g +: 8];
    assign b_arr[g]  = req_b[8*g +: 8];
  end

  alu8_core u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y_s),
`ifdef ALU_SHARE_FLAGS_EN
    .carry (alu_carry_s)
`else
    .carry (unused_alu_carry_s)
`endif
  );

  // Round-robin pick: walk downward so the nearest valid slot at or above rr_q wins
  always_comb begin
    int             idx_i;
    logic [IDW-1:0] idx_s;
    grant_valid_s = 1'b0;
    grant_id_s    = '0;
    idx_i         = 0;
    idx_s         = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_i         = int'(rr_q) + k;
      idx_i         = (idx_i >= NREQ) ? idx_i - NREQ : idx_i;
      idx_s         = IDW'(idx_i);
      grant_valid_s = grant_valid_s | req_valid[idx_s];
      grant_id_s    = req_valid[idx_s] ? idx_s : grant_id_s;
    end
  end

  // FSM next-state, operand capture and response register update
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    req_ready_s = '0;
`ifdef ALU_SHARE_FLAGS_EN
    carry_d     = carry_q;
    zero_d      = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          req_ready_s[grant_id_s] = 1'b1;
          op_d    = op_arr[grant_id_s];
          a_d     = a_arr[grant_id_s];
          b_d     = b_arr[grant_id_s];
          id_d    = grant_id_s;
          rr_d    = (int'(grant_id_s) == NREQ - 1) ? IDW'(0) : grant_id_s + IDW'(1);
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_y_s;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
`ifdef ALU_SHARE_FLAGS_EN
        carry_d     = alu_carry_s;
        zero_d      = (alu_y_s == 8'd0);
`endif
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      op_q        <= 2'b00;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_id_q    <= '0;
`ifdef ALU_SHARE_FLAGS_EN
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
`ifdef ALU_SHARE_FLAGS_EN
      carry_q     <= carry_d;
      zero_q      <= zero_d;
`endif
    end
  end

  // Gated by rst_n so the accept strobe drops the instant reset asserts
  assign req_ready = req_ready_s & {NREQ{rst_n}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);
`ifdef ALU_SHARE_FLAGS_EN
  assign rsp_carry = carry_q;
  assign rsp_zero  = zero_q;
`endif

endmodule
